// File: rtl/ram_burst_reader_pkg.sv
// Shared definitions for the RAM burst reader: FSM state encodings.
package ram_burst_reader_pkg;

    // Controller states, kept as plain two-bit constants so older blocks can reuse them
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ram_burst_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may happen in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read controller: takes (addr, len) requests, reads a 1-cycle-latency RAM
// sequentially and streams the words out on a valid/ready port with backpressure.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [ADDR_WIDTH:0]   req_len,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] LEN_ONE      = LW'(1);
    localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         issued;
    logic                  inflight;
    logic                  inflight_last;

    logic                  accept;
    logic                  pop;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [CW:0]           credit_used;
    logic                  issue_last;

    assign accept      = req_valid && req_ready;
    assign req_ready   = (state == ST_IDLE) && reset_n;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    // Words already buffered plus the one arriving from the RAM this cycle
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign ram_re      = (state == ST_READ) && (issued < len_q) && (credit_used < CREDIT_LIMIT);
    assign ram_addr    = ram_re ? (base_addr + issued[ADDR_WIDTH-1:0]) : '0;
    assign issue_last  = (issued == len_q - LEN_ONE);

    assign m_valid     = !fifo_empty;
    assign pop         = m_valid && m_ready;
    assign m_data      = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last      = m_valid && fifo_head[DATA_WIDTH];

    // Burst sequencing: latch the request, count issued reads, wait for the last beat to leave
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            len_q     <= '0;
            issued    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        base_addr <= req_addr;
                        len_q     <= req_len;
                        issued    <= '0;
                        state     <= (req_len == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (ram_re) begin
                        issued <= issued + LEN_ONE;
                    end
                    if (issued == len_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[DATA_WIDTH]) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Track the read whose data lands next cycle, with its end-of-burst tag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ram_re;
            inflight_last <= ram_re && issue_last;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({inflight_last, ram_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
